midi_parser: RTL and testbench

Byte-level MIDI message assembler between the UART receiver and `voice_controller`. Consumes one received byte per `rx_valid` strobe, tracks status and running status, and skips SysEx, real-time and undefined bytes. It presents each complete channel or system-common message as three bytes, with a level `midi_byte_ready` held until the consumer acknowledges it.

---
 rtl/midi_pkg.sv | 43 ++++
 rtl/midi_parser.sv | 170 +++++++++++++++++
 tb/tb_midi_parser.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, parser state encoding and the
// per-status data-length decode used by midi_parser.
package midi_pkg;

   localparam logic [7:0] NOTE_OFF    = 8'h80;
   localparam logic [7:0] NOTE_ON     = 8'h90;
   localparam logic [7:0] POLY_AT     = 8'hA0;
   localparam logic [7:0] CC          = 8'hB0;
   localparam logic [7:0] PROG        = 8'hC0;
   localparam logic [7:0] CH_AT       = 8'hD0;
   localparam logic [7:0] PITCH       = 8'hE0;
   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] TUNE_REQ    = 8'hF6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_D1,
      ST_WAIT_D2,
      ST_SYSEX
   } parse_state_t;

   // Number of data bytes that follow a status byte (0 for anything that
   // carries no payload or is not a message start).
   function automatic logic [1:0] midi_data_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      case (status[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
         4'hC, 4'hD:                   len = 2'd1;
         4'hF: begin
            case (status)
               8'hF2:        len = 2'd2;
               8'hF1, 8'hF3: len = 2'd1;
               default:      len = 2'd0;
            endcase
         end
         default: len = 2'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/midi_parser.sv
// midi_parser: assembles received MIDI bytes into 3-byte messages with a
// held-until-ack output. Running status is enabled by defining the macro
// MIDI_RUNNING_STATUS_EN; without it every message needs its own status.
module midi_parser
   import midi_pkg::*;
#(
   parameter int CHANNEL_FILTER = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       midi_byte_ack,
   output logic       midi_byte_ready,
   output logic [7:0] midi_byte0,
   output logic [7:0] midi_byte1,
   output logic [7:0] midi_byte2,
   output logic       midi_overflow
);

`ifdef MIDI_RUNNING_STATUS_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   localparam bit         FILTER_EN = (CHANNEL_FILTER < 16);
   localparam logic [3:0] FILTER_CH = CHANNEL_FILTER[3:0];

   parse_state_t state, state_n;
   logic       run_valid, run_valid_n;
   logic [7:0] run_status, run_status_n;
   logic [7:0] msg_status, msg_status_n;
   logic [7:0] d1, d1_n;
   logic       ready_n, overflow_n;
   logic [7:0] byte0_n, byte1_n, byte2_n;
   logic       done, accept;
   logic [7:0] done_status, done_d1, done_d2;

   // Byte classification, parser next state and output-hold decisions.
   always_comb begin
      state_n      = state;
      run_valid_n  = run_valid;
      run_status_n = run_status;
      msg_status_n = msg_status;
      d1_n         = d1;
      done         = 1'b0;
      done_status  = msg_status;
      done_d1      = 8'h00;
      done_d2      = 8'h00;

      if (rx_valid && (rx_byte < 8'hF8)) begin
         if (rx_byte[7]) begin
            case (rx_byte)
               SYSEX_START: begin
                  state_n     = ST_SYSEX;
                  run_valid_n = 1'b0;
               end
               8'hF4, 8'hF5, SYSEX_END: begin
                  state_n     = ST_IDLE;
                  run_valid_n = 1'b0;
               end
               TUNE_REQ: begin
                  state_n     = ST_IDLE;
                  run_valid_n = 1'b0;
                  done        = 1'b1;
                  done_status = rx_byte;
               end
               default: begin
                  msg_status_n = rx_byte;
                  state_n      = ST_WAIT_D1;
                  if (rx_byte < SYSEX_START) begin
                     run_status_n = rx_byte;
                     run_valid_n  = RS_EN;
                  end else begin
                     run_valid_n = 1'b0;
                  end
               end
            endcase
         end else begin
            case (state)
               ST_WAIT_D1: begin
                  d1_n = rx_byte;
                  if (midi_data_len(msg_status) == 2'd2) begin
                     state_n = ST_WAIT_D2;
                  end else begin
                     state_n     = ST_IDLE;
                     done        = 1'b1;
                     done_status = msg_status;
                     done_d1     = rx_byte;
                  end
               end
               ST_WAIT_D2: begin
                  state_n     = ST_IDLE;
                  done        = 1'b1;
                  done_status = msg_status;
                  done_d1     = d1;
                  done_d2     = rx_byte;
               end
               ST_IDLE: begin
                  // A bare data byte restarts the retained channel message.
                  if (RS_EN && run_valid) begin
                     msg_status_n = run_status;
                     d1_n         = rx_byte;
                     if (midi_data_len(run_status) == 2'd2) begin
                        state_n = ST_WAIT_D2;
                     end else begin
                        done        = 1'b1;
                        done_status = run_status;
                        done_d1     = rx_byte;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      // Channel messages for another channel are swallowed without trace.
      accept = done && !(FILTER_EN && (done_status < SYSEX_START) &&
                         (done_status[3:0] != FILTER_CH));

      ready_n    = midi_byte_ready;
      byte0_n    = midi_byte0;
      byte1_n    = midi_byte1;
      byte2_n    = midi_byte2;
      overflow_n = 1'b0;
      if (accept) begin
         if (!midi_byte_ready || midi_byte_ack) begin
            ready_n = 1'b1;
            byte0_n = done_status;
            byte1_n = done_d1;
            byte2_n = done_d2;
         end else begin
            overflow_n = 1'b1;
         end
      end else if (midi_byte_ack) begin
         ready_n = 1'b0;
      end
   end

   // Control state and the held output message.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         run_valid       <= 1'b0;
         midi_byte_ready <= 1'b0;
         midi_byte0      <= 8'h00;
         midi_byte1      <= 8'h00;
         midi_byte2      <= 8'h00;
         midi_overflow   <= 1'b0;
      end else begin
         state           <= state_n;
         run_valid       <= run_valid_n;
         midi_byte_ready <= ready_n;
         midi_byte0      <= byte0_n;
         midi_byte1      <= byte1_n;
         midi_byte2      <= byte2_n;
         midi_overflow   <= overflow_n;
      end
   end

   // Captured status/data bytes; only meaningful when qualified by state.
   always_ff @(posedge clk) begin
      run_status <= run_status_n;
      msg_status <= msg_status_n;
      d1         <= d1_n;
   end

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed scenarios plus randomized byte streams for
// midi_parser, using an omni instance and a channel-2 filtered instance.
module tb_midi_parser;

`ifdef MIDI_RUNNING_STATUS_EN
   localparam bit RS_ON = 1'b1;
`else
   localparam bit RS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset = 1'b1;
   logic            rx_valid = 1'b0;
   logic            ack = 1'b0;
   logic [7:0]      rx_byte = 8'h00;
   logic [1:0]      rdy, ovf;
   logic [1:0][7:0] b0, b1, b2;

   int errors = 0;
   int checks = 0;

   midi_parser #(.CHANNEL_FILTER(16)) u_omni (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .midi_byte_ack(ack), .midi_byte_ready(rdy[0]), .midi_byte0(b0[0]),
      .midi_byte1(b1[0]), .midi_byte2(b2[0]), .midi_overflow(ovf[0]));

   midi_parser #(.CHANNEL_FILTER(2)) u_filt (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .midi_byte_ack(ack), .midi_byte_ready(rdy[1]), .midi_byte0(b0[1]),
      .midi_byte1(b1[1]), .midi_byte2(b2[1]), .midi_overflow(ovf[1]));

   // Reference model: message framing by rule, with a queue of pending data.
   int              p_mode = 0;     // 0 idle, 1 collecting, 2 inside sysex
   logic [7:0]      p_status = 8'h00;
   int              p_need = 0;
   logic [7:0]      p_data[$];
   bit              rs_ok = 1'b0;
   logic [7:0]      rs_stat = 8'h00;
   logic [1:0]      e_rdy = '0, e_ovf = '0;
   logic [1:0][7:0] e_b0 = '0, e_b1 = '0, e_b2 = '0;

   function automatic int filt(input int i);
      return (i == 0) ? 16 : 2;
   endfunction

   function automatic int spec_len(input logic [7:0] s);
      if (s == 8'hF2) return 2;
      if (s == 8'hF1 || s == 8'hF3) return 1;
      if (s >= 8'hF0) return 0;
      if (s[7:4] == 4'hC || s[7:4] == 4'hD) return 1;
      return 2;
   endfunction

   task automatic model_feed(input logic [7:0] b, output bit c,
                             output logic [7:0] c0, output logic [7:0] c1,
                             output logic [7:0] c2);
      c = 1'b0; c0 = 8'h00; c1 = 8'h00; c2 = 8'h00;
      if (b >= 8'hF8) return;
      if (b[7]) begin
         p_data.delete();
         if (b == 8'hF0) begin
            p_mode = 2; rs_ok = 1'b0;
         end else if (b == 8'hF4 || b == 8'hF5 || b == 8'hF7) begin
            p_mode = 0; rs_ok = 1'b0;
         end else if (b == 8'hF6) begin
            c = 1'b1; c0 = 8'hF6; p_mode = 0; rs_ok = 1'b0;
         end else begin
            p_status = b; p_need = spec_len(b); p_mode = 1;
            if (b < 8'hF0) begin
               rs_ok = RS_ON; rs_stat = b;
            end else begin
               rs_ok = 1'b0;
            end
         end
         return;
      end
      if (p_mode == 0 && rs_ok) begin
         p_status = rs_stat; p_need = spec_len(rs_stat); p_mode = 1;
         p_data.delete();
      end
      if (p_mode == 1) begin
         p_data.push_back(b);
         if (p_data.size() == p_need) begin
            c  = 1'b1;
            c0 = p_status;
            c1 = p_data[0];
            c2 = (p_need == 2) ? p_data[1] : 8'h00;
            p_mode = 0;
            p_data.delete();
         end
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] b,
                             input bit a);
      bit         c, pass;
      logic [7:0] c0, c1, c2;
      if (r) begin
         p_mode = 0; p_data.delete(); rs_ok = 1'b0;
         e_rdy = '0; e_ovf = '0; e_b0 = '0; e_b1 = '0; e_b2 = '0;
         return;
      end
      c = 1'b0; c0 = 8'h00; c1 = 8'h00; c2 = 8'h00;
      if (v) model_feed(b, c, c0, c1, c2);
      for (int i = 0; i < 2; i++) begin
         pass = c && !((c0 < 8'hF0) && (filt(i) < 16) &&
                       (int'(c0[3:0]) != filt(i)));
         e_ovf[i] = 1'b0;
         if (pass) begin
            if (!e_rdy[i] || a) begin
               e_rdy[i] = 1'b1; e_b0[i] = c0; e_b1[i] = c1; e_b2[i] = c2;
            end else begin
               e_ovf[i] = 1'b1;
            end
         end else if (a) begin
            e_rdy[i] = 1'b0;
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, settle to negedge.
   task automatic tick(input bit r, input bit v, input logic [7:0] b, input bit a);
      reset = r; rx_valid = v; rx_byte = b; ack = a;
      @(posedge clk);
      model_step(r, v, b, a);
      @(negedge clk);
      reset = 1'b0; rx_valid = 1'b0; ack = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b0, 1'b1, b, 1'b0);
   endtask

   task automatic do_ack();
      tick(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      tick(1'b1, 1'b1, 8'h92, 1'b0);
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({rdy[i], b0[i], b1[i], b2[i], ovf[i]} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state inst=%0d got=%h exp=0", i,
                     {rdy[i], b0[i], b1[i], b2[i], ovf[i]});
         end
      end
   endtask

   task automatic test_basic();
      send(8'h92); send(8'h3C);
      checks++;
      if (rdy[0] !== 1'b0) begin
         errors++; $display("FAIL basic_early_ready got=%b exp=0", rdy[0]);
      end
      send(8'h64);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({rdy[0], b0[0], b1[0], b2[0]} !== {1'b1, 8'h92, 8'h3C, 8'h64}) begin
            errors++;
            $display("FAIL basic_hold cyc=%0d got=%h exp=%h", k,
                     {rdy[0], b0[0], b1[0], b2[0]}, {1'b1, 8'h92, 8'h3C, 8'h64});
         end
         tick(1'b0, 1'b0, 8'h00, 1'b0);
      end
      do_ack();
      checks++;
      if (rdy !== 2'b00) begin
         errors++; $display("FAIL basic_ack_clears got=%b exp=00", rdy);
      end
   endtask

   task automatic test_running();
      send(8'h90); send(8'h40); send(8'h7F);
      checks++;
      if ({rdy, b0[0], b1[0], b2[0]} !== {2'b01, 8'h90, 8'h40, 8'h7F}) begin
         errors++;
         $display("FAIL running_first got=%h exp=%h",
                  {rdy, b0[0], b1[0], b2[0]}, {2'b01, 8'h90, 8'h40, 8'h7F});
      end
      do_ack();
      send(8'h41); send(8'h00);
      checks++;
      if (RS_ON) begin
         if ({rdy[0], b0[0], b1[0], b2[0]} !== {1'b1, 8'h90, 8'h41, 8'h00}) begin
            errors++;
            $display("FAIL running_second got=%h exp=%h",
                     {rdy[0], b0[0], b1[0], b2[0]}, {1'b1, 8'h90, 8'h41, 8'h00});
         end
      end else if (rdy[0] !== 1'b0) begin
         errors++; $display("FAIL running_disabled got=%b exp=0", rdy[0]);
      end
      do_ack();
   endtask

   task automatic test_realtime();
      send(8'h90); send(8'h40); send(8'hF8); send(8'h7F);
      checks++;
      if ({rdy[0], b0[0], b1[0], b2[0]} !== {1'b1, 8'h90, 8'h40, 8'h7F}) begin
         errors++;
         $display("FAIL realtime_msg got=%h exp=%h",
                  {rdy[0], b0[0], b1[0], b2[0]}, {1'b1, 8'h90, 8'h40, 8'h7F});
      end
      do_ack();
   endtask

   task automatic test_sysex();
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h06);
      checks++;
      if (rdy !== 2'b00) begin
         errors++; $display("FAIL sysex_skipped got=%b exp=00", rdy);
      end
      send(8'hC3); send(8'h05);
      checks++;
      if ({rdy, b0[0], b1[0], b2[0]} !== {2'b01, 8'hC3, 8'h05, 8'h00}) begin
         errors++;
         $display("FAIL sysex_prog got=%h exp=%h",
                  {rdy, b0[0], b1[0], b2[0]}, {2'b01, 8'hC3, 8'h05, 8'h00});
      end
      do_ack();
      send(8'h06);
      checks++;
      if (RS_ON) begin
         if ({rdy[0], b0[0], b1[0], b2[0]} !== {1'b1, 8'hC3, 8'h06, 8'h00}) begin
            errors++;
            $display("FAIL prog_running got=%h exp=%h",
                     {rdy[0], b0[0], b1[0], b2[0]}, {1'b1, 8'hC3, 8'h06, 8'h00});
         end
      end else if (rdy[0] !== 1'b0) begin
         errors++; $display("FAIL prog_no_running got=%b exp=0", rdy[0]);
      end
      do_ack();
      send(8'hF6);
      checks++;
      if ({rdy, b0[1], b1[1], b2[1]} !== {2'b11, 8'hF6, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL tune_req got=%h exp=%h",
                  {rdy, b0[1], b1[1], b2[1]}, {2'b11, 8'hF6, 8'h00, 8'h00});
      end
      do_ack();
   endtask

   task automatic test_overflow();
      send(8'h90); send(8'h3C); send(8'h40);
      send(8'h80); send(8'h3C); send(8'h00);
      checks++;
      if ({rdy[0], b0[0], b1[0], b2[0], ovf} !== {1'b1, 8'h90, 8'h3C, 8'h40, 2'b01}) begin
         errors++;
         $display("FAIL overflow_pulse got=%h exp=%h",
                  {rdy[0], b0[0], b1[0], b2[0], ovf}, {1'b1, 8'h90, 8'h3C, 8'h40, 2'b01});
      end
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (ovf !== 2'b00) begin
         errors++; $display("FAIL overflow_once got=%b exp=00", ovf);
      end
      send(8'h90); send(8'h3D);
      tick(1'b0, 1'b1, 8'h41, 1'b1);
      checks++;
      if ({rdy[0], b0[0], b1[0], b2[0], ovf[0]} !== {1'b1, 8'h90, 8'h3D, 8'h41, 1'b0}) begin
         errors++;
         $display("FAIL ack_same_cycle got=%h exp=%h",
                  {rdy[0], b0[0], b1[0], b2[0], ovf[0]}, {1'b1, 8'h90, 8'h3D, 8'h41, 1'b0});
      end
      do_ack();
   endtask

   task automatic test_filter();
      send(8'h91); send(8'h3C); send(8'h40);
      checks++;
      if (rdy !== 2'b01) begin
         errors++; $display("FAIL filter_other_ch got=%b exp=01", rdy);
      end
      do_ack();
      send(8'h92); send(8'h3C); send(8'h40);
      checks++;
      if ({rdy[1], b0[1], b1[1], b2[1]} !== {1'b1, 8'h92, 8'h3C, 8'h40}) begin
         errors++;
         $display("FAIL filter_own_ch got=%h exp=%h",
                  {rdy[1], b0[1], b1[1], b2[1]}, {1'b1, 8'h92, 8'h3C, 8'h40});
      end
      send(8'h92); send(8'h3C);
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if ({rdy, b0[0], b0[1]} !== 18'd0) begin
         errors++;
         $display("FAIL reset_drops_held got=%h exp=0", {rdy, b0[0], b0[1]});
      end
      send(8'h40);
      checks++;
      if (rdy !== 2'b00) begin
         errors++; $display("FAIL reset_drops_partial got=%b exp=00", rdy);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         cls;
      bit         v, a, r;
      for (int n = 0; n < 4000; n++) begin
         cls = $urandom_range(0, 9);
         case (cls)
            0, 1, 2, 3: b = 8'($urandom_range(0, 127));
            4, 5, 6:    b = 8'($urandom_range(8'h80, 8'hEF));
            7:          b = 8'($urandom_range(8'hF0, 8'hF7));
            8:          b = 8'($urandom_range(8'hF8, 8'hFF));
            default:    b = {1'b1, 3'($urandom_range(0, 6)), 4'h2};
         endcase
         v = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 499) == 0);
         tick(r, v, b, a);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rdy[i], b0[i], b1[i], b2[i], ovf[i]} !==
                {e_rdy[i], e_b0[i], e_b1[i], e_b2[i], e_ovf[i]}) begin
               errors++;
               $display("FAIL random n=%0d inst=%0d byte=%h got=%h exp=%h", n, i, b,
                        {rdy[i], b0[i], b1[i], b2[i], ovf[i]},
                        {e_rdy[i], e_b0[i], e_b1[i], e_b2[i], e_ovf[i]});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_running();
      test_realtime();
      test_sysex();
      test_overflow();
      test_filter();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
